// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - opcode constants and sequencer state type shared with the ALU side
package alu_pkg;

  localparam logic [2:0] ADD = 3'd0;
  localparam logic [2:0] SUB = 3'd1;
  localparam logic [2:0] DIV = 3'd2;
  localparam logic [2:0] MUL = 3'd3;
  localparam logic [2:0] OR  = 3'd4;
  localparam logic [2:0] NOT = 3'd5;
  localparam logic [2:0] SHL = 3'd6;
  localparam logic [2:0] SHR = 3'd7;

  typedef enum logic [2:0] {
    GET_OP  = 3'd0,
    GET_A   = 3'd1,
    GET_B   = 3'd2,
    EXEC    = 3'd3,
    SEND_LO = 3'd4,
    SEND_HI = 3'd5
  } seq_state_t;

endpackage

// File: rtl/alu_cmd_sequencer.sv
// rtl/alu_cmd_sequencer.sv - byte-stream command front end for the combinational 8-bit ALU
module alu_cmd_sequencer
  import alu_pkg::*;
#(
  parameter int EXEC_WAIT = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [2:0]  alu_op,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  input  logic [15:0] alu_result,
  output logic        busy,
  output logic        err
);

  // One counter serves both the inter-byte timeout and the EXEC settle wait.
  localparam int CNT_MAX = (EXEC_WAIT > TIMEOUT) ? EXEC_WAIT : TIMEOUT;
  localparam int CW      = (CNT_MAX > 1) ? $clog2(CNT_MAX + 1) : 1;

  seq_state_t    state, state_n;
  logic [CW-1:0] cnt, cnt_n;
  logic [2:0]    op_n;
  logic [7:0]    a_n, b_n;
  logic [15:0]   result, result_n;
  logic          err_n;
  logic          in_fire, out_fire, tmo_hit, exec_last;

  assign in_ready  = (state == GET_OP) || (state == GET_A) || (state == GET_B);
  assign out_valid = (state == SEND_LO) || (state == SEND_HI);
  assign busy      = (state != GET_OP);
  assign out_data  = (state == SEND_HI) ? result[15:8] : result[7:0];
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign tmo_hit   = (TIMEOUT != 0) && (int'(cnt) == TIMEOUT - 1);
  assign exec_last = (int'(cnt) == EXEC_WAIT - 1);

  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    op_n     = alu_op;
    a_n      = alu_a;
    b_n      = alu_b;
    result_n = result;
    err_n    = 1'b0;
    case (state)
      GET_OP: begin
        cnt_n = '0;
        if (in_fire) begin
          if (in_data[7:3] == 5'd0) begin
            op_n    = in_data[2:0];
            state_n = GET_A;
          end else begin
            err_n = 1'b1;
          end
        end
      end
      GET_A: begin
        if (in_fire) begin
          cnt_n = '0;
          a_n   = in_data;
          if (alu_op == NOT) begin
            b_n     = 8'd0;
            state_n = EXEC;
          end else begin
            state_n = GET_B;
          end
        end else if (tmo_hit) begin
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = GET_OP;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      GET_B: begin
        if (in_fire) begin
          cnt_n   = '0;
          b_n     = in_data;
          state_n = EXEC;
        end else if (tmo_hit) begin
          cnt_n   = '0;
          err_n   = 1'b1;
          state_n = GET_OP;
        end else if (TIMEOUT != 0) begin
          cnt_n = cnt + 1'b1;
        end
      end
      EXEC: begin
        // Operands are registered, so the ALU has been settling since entry.
        if (exec_last) begin
          cnt_n    = '0;
          result_n = alu_result;
          state_n  = SEND_LO;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      SEND_LO: if (out_fire) state_n = SEND_HI;
      SEND_HI: if (out_fire) state_n = GET_OP;
      default: state_n = GET_OP;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= GET_OP;
      cnt    <= '0;
      alu_op <= 3'd0;
      alu_a  <= 8'd0;
      alu_b  <= 8'd0;
      result <= 16'd0;
      err    <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      alu_op <= op_n;
      alu_a  <= a_n;
      alu_b  <= b_n;
      result <= result_n;
      err    <= err_n;
    end
  end

endmodule
